// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: round-robin AXI-Stream frame arbiter with MAX_BEATS truncation.
//   clk, rst (async, active-high)
//   port_en             per-port arbitration enable, sampled only while idle
//   s_t*                per-port upstream streams, packed port-major
//   m_t*                registered downstream stream
//   grant, busy         current/last granted port, FORWARD or DRAIN active
//   trunc_count         saturating count of frames cut at MAX_BEATS
module axis_frame_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BEATS = 512,
  localparam int GW = $clog2(NUM_PORTS),
  localparam int BW = $clog2(MAX_BEATS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_en,
  input  logic [NUM_PORTS-1:0]             s_tvalid,
  output logic [NUM_PORTS-1:0]             s_tready,
  input  logic [NUM_PORTS-1:0]             s_tlast,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [USER_WIDTH-1:0]            m_tuser,
  output logic [GW-1:0]                    grant,
  output logic                             busy,
  output logic [15:0]                      trunc_count
);
  typedef enum logic [1:0] {IDLE, FORWARD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick, cand;
  logic [BW-1:0] beat_q, beat_d;
  logic [15:0] tc_q, tc_d;
  logic mv_q, mv_d, ml_q, ml_d;
  logic [DATA_WIDTH-1:0] md_q, md_d, sd;
  logic [USER_WIDTH-1:0] mu_q, mu_d, su;
  logic found, sv, sl, acc, load, trunc;
  // Scan downward so the port closest above last_q is the one left in pick.
  always_comb begin
    pick = last_q;
    found = 1'b0;
    cand = last_q;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NUM_PORTS);
      if (s_tvalid[cand] & port_en[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    s_tready = '0;
    s_tready[grant_q] = (state_q == FORWARD) ? (m_tready | ~mv_q) : (state_q == DRAIN);
  end
  assign sv = s_tvalid[grant_q];
  assign sl = s_tlast[grant_q];
  assign sd = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign su = s_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
  assign acc = sv & s_tready[grant_q];
  assign load = acc & (state_q == FORWARD);
  assign trunc = load & ~sl & (beat_q == BW'(MAX_BEATS - 1));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    beat_d = beat_q;
    tc_d = tc_q;
    mv_d = load | (mv_q & ~m_tready);
    md_d = load ? sd : md_q;
    ml_d = load ? (sl | trunc) : ml_q;
    mu_d = load ? (trunc ? (su | USER_WIDTH'(1)) : su) : mu_q;
    if (state_q == IDLE && found) begin
      state_d = FORWARD;
      grant_d = pick;
      beat_d = '0;
    end
    if (load) beat_d = beat_q + BW'(1);
    if (acc & sl) begin
      state_d = IDLE;
      last_d = grant_q;
    end else if (trunc) begin
      state_d = DRAIN;
      tc_d = tc_q + 16'(tc_q != 16'hFFFF);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_PORTS - 1);
      beat_q <= '0;
      tc_q <= '0;
      mv_q <= 1'b0;
      ml_q <= 1'b0;
      md_q <= '0;
      mu_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beat_q <= beat_d;
      tc_q <= tc_d;
      mv_q <= mv_d;
      ml_q <= ml_d;
      md_q <= md_d;
      mu_q <= mu_d;
    end
  end
  assign m_tvalid = mv_q;
  assign m_tlast = ml_q;
  assign m_tdata = md_q;
  assign m_tuser = mu_q;
  assign grant = grant_q;
  assign busy = state_q != IDLE;
  assign trunc_count = tc_q;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter: directed checks of arbitration, flow control, truncation and reset.
module tb_axis_frame_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [N-1:0] port_en = '1, s_tvalid = '0, s_tlast = '0, s_tuser = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic m_tready = 1'b1;
  logic [N-1:0] rdy_a, rdy_b, rdy;
  logic mv_a, mv_b, ml_a, ml_b, busy_a, busy_b, mv, ml;
  logic [0:0] mu_a, mu_b, mu;
  logic [DW-1:0] md_a, md_b, md;
  logic [1:0] g_a, g_b, mg;
  logic [15:0] tc_a, tc_b;
  logic [33:0] q [N][$];
  logic [33:0] olog [$];
  int ocyc [$];
  logic [1:0] glog [$];
  logic [N-1:0] acc = '0;
  logic pstall = 1'b0;
  logic [DW-1:0] pdata = '0;
  int cyc = 0, viol = 0, nstall = 0, n_run = 0, n_fail = 0;
  logic rpat [$];

  always #5 clk = ~clk;

  axis_frame_arbiter dut_a (
    .clk(clk), .rst(rst), .port_en(port_en), .s_tvalid(s_tvalid), .s_tready(rdy_a),
    .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tuser(s_tuser), .m_tvalid(mv_a),
    .m_tready(m_tready), .m_tlast(ml_a), .m_tdata(md_a), .m_tuser(mu_a),
    .grant(g_a), .busy(busy_a), .trunc_count(tc_a)
  );
  axis_frame_arbiter #(.MAX_BEATS(4)) dut_b (
    .clk(clk), .rst(rst), .port_en(port_en), .s_tvalid(s_tvalid), .s_tready(rdy_b),
    .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tuser(s_tuser), .m_tvalid(mv_b),
    .m_tready(m_tready), .m_tlast(ml_b), .m_tdata(md_b), .m_tuser(mu_b),
    .grant(g_b), .busy(busy_b), .trunc_count(tc_b)
  );

  assign rdy = sel ? rdy_b : rdy_a;
  assign mv = sel ? mv_b : mv_a;
  assign ml = sel ? ml_b : ml_a;
  assign mu = sel ? mu_b : mu_a;
  assign md = sel ? md_b : md_a;
  assign mg = sel ? g_b : g_a;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] bt(int p, int t, int b, logic l, logic u);
    return {l, u, 32'((p << 12) | (t << 8) | b)};
  endfunction

  task automatic frame(int p, int t, int n);
    for (int b = 0; b < n; b++) q[p].push_back(bt(p, t, b, b == n - 1, 1'b0));
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) begin
      for (int p = 0; p < N; p++) q[p].delete();
    end else begin
      for (int p = 0; p < N; p++) if (acc[p]) void'(q[p].pop_front());
    end
    m_tready = (rpat.size() != 0) ? rpat.pop_front() : 1'b1;
    for (int p = 0; p < N; p++) begin
      s_tvalid[p] = q[p].size() != 0;
      {s_tlast[p], s_tuser[p], s_tdata[p*DW +: DW]} = (q[p].size() != 0) ? q[p][0] : 34'd0;
    end
    #1;
    acc = rst ? '0 : (s_tvalid & rdy);
    if (!rst) begin
      if (mv && m_tready) begin
        olog.push_back({ml, mu, md});
        ocyc.push_back(cyc);
      end
      if (|acc) glog.push_back(mg);
      if (pstall && md !== pdata) viol++;
      pstall = mv && !m_tready;
      pdata = md;
      if (pstall) nstall++;
    end
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    olog.delete();
    ocyc.delete();
    glog.delete();
    viol = 0;
    nstall = 0;
    pstall = 1'b0;
  endtask

  initial begin
    run(2);
    chk("rst_mvalid", mv_a, 0);
    chk("rst_mlast", ml_a, 0);
    chk("rst_mdata", md_a, 0);
    chk("rst_muser", mu_a, 0);
    chk("rst_sready", rdy_a, 0);
    chk("rst_grant", g_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_trunc", tc_a, 0);
    rst = 1'b0;

    frame(0, 0, 3);
    frame(2, 0, 3);
    run(16);
    chk("rr2_count", olog.size(), 6);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr2_p0_b%0d", i), olog[i], bt(0, 0, i, i == 2, 1'b0));
      chk($sformatf("rr2_p2_b%0d", i), olog[i+3], bt(2, 0, i, i == 2, 1'b0));
    end
    chk("rr2_gap1", ocyc[1] - ocyc[0], 1);
    chk("rr2_gap2", ocyc[2] - ocyc[0], 2);
    chk("rr2_gap3", ocyc[3] - ocyc[0], 4);
    chk("rr2_gap5", ocyc[5] - ocyc[0], 6);

    reset_dut();
    for (int p = 0; p < N; p++) begin
      frame(p, 0, 1);
      frame(p, 1, 1);
    end
    run(24);
    chk("rr4_count", olog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr4_data%0d", i), olog[i], bt(i % 4, i / 4, 0, 1'b1, 1'b0));
      chk($sformatf("rr4_grant%0d", i), glog[i], i % 4);
    end

    reset_dut();
    frame(3, 2, 5);
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run(20);
    chk("stall_count", olog.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("stall_b%0d", i), olog[i], bt(3, 2, i, i == 4, 1'b0));
    chk("stall_stable", viol, 0);
    chk("stall_seen", nstall != 0, 1);

    sel = 1'b1;
    reset_dut();
    frame(1, 3, 7);
    run(20);
    chk("trunc_count_beats", olog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("trunc_b%0d", i), olog[i], bt(1, 3, i, i == 3, i == 3));
    chk("trunc_cnt", tc_b, 1);
    chk("trunc_idle", busy_b, 0);
    chk("trunc_drained", q[1].size(), 0);
    sel = 1'b0;

    reset_dut();
    port_en = 4'b1011;
    frame(2, 0, 2);
    run(6);
    chk("en_busy", busy_a, 0);
    chk("en_nobeats", olog.size(), 0);
    chk("en_nogrant", glog.size(), 0);
    reset_dut();
    port_en = 4'hF;
    frame(1, 4, 4);
    run(3);
    port_en = 4'b1001;
    run(10);
    chk("en_mid_count", olog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("en_mid_b%0d", i), olog[i], bt(1, 4, i, i == 3, 1'b0));
    port_en = 4'hF;

    reset_dut();
    frame(3, 5, 4);
    run(3);
    chk("ar_pre_valid", mv_a, 1);
    chk("ar_pre_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_mvalid", mv_a, 0);
    chk("ar_sready", rdy_a, 0);
    chk("ar_trunc", tc_a, 0);
    chk("ar_busy", busy_a, 0);
    run(2);
    rst = 1'b0;
    olog.delete();
    glog.delete();
    frame(3, 6, 2);
    frame(0, 6, 2);
    run(12);
    chk("ar_count", olog.size(), 4);
    chk("ar_first", olog[0], bt(0, 6, 0, 1'b0, 1'b0));
    chk("ar_first_grant", glog[0], 0);
    chk("ar_second", olog[2], bt(3, 6, 0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
